// File: rtl/present_pkg.sv
// Shared PRESENT constants: S-box, legal key widths, round-key width and last round index.
package present_pkg;

  localparam int KEY_W_80  = 80;
  localparam int KEY_W_128 = 128;
  localparam int RK_W      = 64;
  localparam int LAST_RND  = 32;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

endpackage

// File: rtl/present_key_schedule_if.sv
// Key-input / round-key bus between the key source, the key schedule and the addRoundKey stage.
interface present_key_schedule_if #(
  parameter int KEY_W = present_pkg::KEY_W_80,
  parameter int RK_W  = present_pkg::RK_W
);

  logic [KEY_W-1:0] key_in;
  logic             load;
  logic             step;
  logic [RK_W-1:0]  round_key;
  logic [5:0]       round_idx;
  logic             key_valid;
  logic             done;

  modport master (
    output key_in, load, step,
    input  round_key, round_idx, key_valid, done
  );

  modport slave (
    input  key_in, load, step,
    output round_key, round_idx, key_valid, done
  );

endinterface

// File: rtl/present_key_update.sv
// Combinational PRESENT key-update: rotate left 61, S-box the top nibble(s), XOR the round counter.
module present_key_update
  import present_pkg::*;
#(
  parameter int KEY_W = KEY_W_80
) (
  input  logic [KEY_W-1:0] key_i,
  input  logic [4:0]       cnt_i,
  output logic [KEY_W-1:0] key_o
);

  logic [KEY_W-1:0] rot;

  assign rot = {key_i[KEY_W-62:0], key_i[KEY_W-1:KEY_W-61]};

  if (KEY_W == KEY_W_128) begin : g_k128
    always_comb begin
      key_o          = rot;
      key_o[127:124] = sbox4(rot[127:124]);
      key_o[123:120] = sbox4(rot[123:120]);
      key_o[66:62]   = rot[66:62] ^ cnt_i;
    end
  end else begin : g_k80
    always_comb begin
      key_o        = rot;
      key_o[79:76] = sbox4(rot[79:76]);
      key_o[19:15] = rot[19:15] ^ cnt_i;
    end
  end

endmodule

// File: rtl/present_key_schedule.sv
// PRESENT key-schedule register: holds the key state, updates it one round per step and
// presents round keys K1..K32 with their index.
module present_key_schedule #(
  parameter int KEY_W    = present_pkg::KEY_W_80,
  parameter int RK_W     = present_pkg::RK_W,
  parameter int LAST_RND = present_pkg::LAST_RND
) (
  input  logic                   clk,
  input  logic                   rst_n,
  present_key_schedule_if.slave  bus
);

  import present_pkg::*;

  if (KEY_W != KEY_W_80 && KEY_W != KEY_W_128) begin : g_bad_key_w
    $fatal(1, "present_key_schedule: KEY_W must be 80 or 128");
  end
  if (RK_W != 64) begin : g_bad_rk_w
    $fatal(1, "present_key_schedule: RK_W must be 64");
  end
  if (LAST_RND < 2 || LAST_RND > 32) begin : g_bad_last_rnd
    $fatal(1, "present_key_schedule: LAST_RND must lie in 2..32");
  end

  // Bit 0 doubles as key_valid and bit 1 as done, so both outputs are plain register slices.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACTIVE = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b11;

  logic [KEY_W-1:0] key_q, key_d, key_upd;
  logic [5:0]       idx_q, idx_d;
  logic [1:0]       state_q, state_d;

  present_key_update #(
    .KEY_W (KEY_W)
  ) u_update (
    .key_i (key_q),
    .cnt_i (idx_q[4:0]),
    .key_o (key_upd)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latch).
    key_d   = key_q;
    idx_d   = idx_q;
    state_d = state_q;
    if (bus.load) begin
      key_d   = bus.key_in;
      idx_d   = 6'd1;
      state_d = ST_ACTIVE;
    end else if (bus.step && state_q == ST_ACTIVE) begin
      key_d = key_upd;
      idx_d = idx_q + 6'd1;
      if (idx_d == 6'(LAST_RND)) begin
        state_d = ST_DONE;
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      idx_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      key_q   <= key_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  assign bus.round_key = key_q[KEY_W-1 -: RK_W];
  assign bus.round_idx = idx_q;
  assign bus.key_valid = state_q[0];
  assign bus.done      = state_q[1];

endmodule

// File: tb/tb_present_key_schedule.sv
// Bench for present_key_schedule: 80- and 128-bit instances checked against fixed vectors and a
// behavioural key-schedule model under random load/step traffic.
module tb_present_key_schedule;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  present_key_schedule_if #(.KEY_W(80))  if80  ();
  present_key_schedule_if #(.KEY_W(128)) if128 ();

  present_key_schedule #(.KEY_W(80)) dut80 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if80.slave)
  );

  present_key_schedule #(.KEY_W(128)) dut128 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if128.slave)
  );

  localparam logic [3:0] SBOX_REF [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef struct {
    logic [63:0] rk;
    logic [5:0]  idx;
    logic        valid;
    logic        done;
  } obs_t;

  typedef struct {
    int           s;
    logic [127:0] key;
    int           nsteps;
    logic [63:0]  rk;
    int           idx;
    bit           done;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state, index 0 = 80-bit instance, 1 = 128-bit instance.
  logic [127:0] m_key   [2];
  int           m_idx   [2];
  bit           m_valid [2];
  bit           m_done  [2];

  function automatic int kw(input int s);
    return (s == 0) ? 80 : 128;
  endfunction

  function automatic logic [127:0] kmask(input int w);
    return (w == 80) ? ((128'd1 << 80) - 128'd1) : {128{1'b1}};
  endfunction

  function automatic logic [127:0] ref_update(input logic [127:0] k, input int w, input int i);
    logic [127:0] r;
    logic [3:0]   nib;
    r = ((k << 61) | (k >> (w - 61))) & kmask(w);
    for (int n = 1; n <= ((w == 128) ? 2 : 1); n++) begin
      nib = 4'((r >> (w - 4 * n)) & 128'hF);
      r   = (r & ~(128'hF << (w - 4 * n))) | (128'(SBOX_REF[nib]) << (w - 4 * n));
    end
    r = r ^ (128'(i % 32) << ((w == 80) ? 15 : 62));
    return r;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_key[s]   = '0;
      m_idx[s]   = 0;
      m_valid[s] = 1'b0;
      m_done[s]  = 1'b0;
    end
  endfunction

  function automatic void model_step(input int s, input bit ld, input bit st, input logic [127:0] key);
    if (ld) begin
      m_key[s]   = key & kmask(kw(s));
      m_idx[s]   = 1;
      m_valid[s] = 1'b1;
      m_done[s]  = 1'b0;
    end else if (st && m_valid[s] && !m_done[s]) begin
      m_key[s]  = ref_update(m_key[s], kw(s), m_idx[s]);
      m_idx[s]  = m_idx[s] + 1;
      m_done[s] = (m_idx[s] == 32);
    end
  endfunction

  function automatic obs_t observe(input int s);
    obs_t o;
    if (s == 0) begin
      o.rk = if80.round_key;  o.idx = if80.round_idx;
      o.valid = if80.key_valid; o.done = if80.done;
    end else begin
      o.rk = if128.round_key; o.idx = if128.round_idx;
      o.valid = if128.key_valid; o.done = if128.done;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input int s, input bit ld, input bit st, input logic [127:0] key);
    if (s == 0) begin
      if80.load = ld; if80.step = st; if80.key_in = key[79:0];
    end else begin
      if128.load = ld; if128.step = st; if128.key_in = key;
    end
  endtask

  // Inputs are applied now, the DUT updates on the next rising edge, outputs are sampled 1 ns later.
  task automatic cycle(input int s, input bit ld, input bit st, input logic [127:0] key);
    drive(s, ld, st, key);
    model_step(s, ld, st, key);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input int s, input string tag);
    obs_t o;
    o = observe(s);
    check($sformatf("%s rk", tag),    128'(o.rk),    m_key[s] >> (kw(s) - 64));
    check($sformatf("%s idx", tag),   128'(o.idx),   128'(m_idx[s]));
    check($sformatf("%s valid", tag), 128'(o.valid), 128'(m_valid[s]));
    check($sformatf("%s done", tag),  128'(o.done),  128'(m_done[s]));
  endtask

  task automatic check_reset_values(input string tag);
    for (int s = 0; s < 2; s++) begin
      obs_t o;
      o = observe(s);
      check($sformatf("%s w%0d rk", tag, kw(s)),    128'(o.rk),    128'd0);
      check($sformatf("%s w%0d idx", tag, kw(s)),   128'(o.idx),   128'd0);
      check($sformatf("%s w%0d valid", tag, kw(s)), 128'(o.valid), 128'd0);
      check($sformatf("%s w%0d done", tag, kw(s)),  128'(o.done),  128'd0);
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish within 200 us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs [$];
    obs_t         o;
    int           s;
    int           done_at;
    int           max_idx;
    bit           ld, st;
    logic [127:0] key, key2;

    vecs.push_back('{0, 128'h0, 0, 64'h0000000000000000, 1, 1'b0});
    vecs.push_back('{0, 128'h0, 1, 64'hC000000000000000, 2, 1'b0});
    vecs.push_back('{1, 128'h0, 1, 64'hCC00000000000000, 2, 1'b0});
    vecs.push_back('{0, 128'h0, 31, 64'h6DAB31744F41D700, 32, 1'b1});
    vecs.push_back('{0, 128'hFFFF_FFFFFFFFFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF, 1, 1'b0});
    vecs.push_back('{0, 128'hFFFF_FFFFFFFFFFFFFFFF, 1, 64'h2FFFFFFFFFFFFFFF, 2, 1'b0});
    vecs.push_back('{1, 128'h0123456789ABCDEF_FEDCBA9876543210, 0, 64'h0123456789ABCDEF, 1, 1'b0});
    vecs.push_back('{1, 128'h0, 0, 64'h0, 1, 1'b0});

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0);
    model_reset();
    #12;
    check_reset_values("reset");
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Step while idle must be ignored.
    cycle(0, 1'b0, 1'b1, '0);
    cycle(1, 1'b0, 1'b1, '0);
    drive(0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0);
    check_reset_values("idle step");

    // Fixed vectors: load, then nsteps consecutive steps.
    foreach (vecs[v]) begin
      s = vecs[v].s;
      cycle(s, 1'b1, 1'b0, vecs[v].key);
      for (int n = 0; n < vecs[v].nsteps; n++) cycle(s, 1'b0, 1'b1, '0);
      drive(s, 1'b0, 1'b0, '0);
      o = observe(s);
      check($sformatf("vec%0d rk", v),    128'(o.rk),    128'(vecs[v].rk));
      check($sformatf("vec%0d idx", v),   128'(o.idx),   128'(vecs[v].idx));
      check($sformatf("vec%0d valid", v), 128'(o.valid), 128'd1);
      check($sformatf("vec%0d done", v),  128'(o.done),  128'(vecs[v].done));
      compare_model(s, $sformatf("vec%0d model", v));
    end

    // Step held high after load: one update per cycle, done exactly 31 cycles later, then frozen.
    cycle(0, 1'b1, 1'b0, 128'hFFFF_FFFFFFFFFFFFFFFF);
    done_at = -1;
    max_idx = 0;
    for (int c = 1; c <= 40; c++) begin
      cycle(0, 1'b0, 1'b1, '0);
      compare_model(0, $sformatf("held c%0d", c));
      o = observe(0);
      if (int'(o.idx) > max_idx) max_idx = int'(o.idx);
      if (o.done && done_at < 0) done_at = c;
    end
    drive(0, 1'b0, 1'b0, '0);
    check("held done latency", 128'(done_at), 128'd31);
    check("held max idx", 128'(max_idx), 128'd32);

    // Load and step together at idx 10: load wins.
    key  = 128'h00112233445566778899AABBCCDDEEFF;
    key2 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    cycle(1, 1'b1, 1'b0, key);
    for (int n = 0; n < 9; n++) cycle(1, 1'b0, 1'b1, '0);
    o = observe(1);
    check("pre-collide idx", 128'(o.idx), 128'd10);
    cycle(1, 1'b1, 1'b1, key2);
    drive(1, 1'b0, 1'b0, '0);
    o = observe(1);
    check("collide rk", 128'(o.rk), 128'(key2[127:64]));
    check("collide idx", 128'(o.idx), 128'd1);
    compare_model(1, "collide model");

    // Asynchronous reset mid-schedule, asserted between clock edges.
    cycle(0, 1'b1, 1'b0, rand_key());
    for (int n = 0; n < 5; n++) cycle(0, 1'b0, 1'b1, '0);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("async reset");
    drive(0, 1'b0, 1'b1, '0);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_step(0, 1'b0, 1'b1, '0);
    compare_model(0, "post reset step");
    drive(0, 1'b0, 1'b0, '0);

    // Random traffic on both widths against the model.
    for (int t = 0; t < 8; t++) begin
      s = t % 2;
      cycle(s, 1'b1, 1'b0, rand_key());
      compare_model(s, $sformatf("rnd t%0d load", t));
      for (int c = 0; c < 40; c++) begin
        ld = ($urandom_range(0, 29) == 0);
        st = ($urandom_range(0, 3) != 0);
        cycle(s, ld, st, rand_key());
        compare_model(s, $sformatf("rnd t%0d c%0d", t, c));
      end
      drive(s, 1'b0, 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
